i2s_mic_rx: RTL and testbench

Capture side of the microphone I2S link: deserializes 24-bit left/right samples from `LINES` shared serial data lines using the 2 MHz bit clock and word-select strobe generated by the clock manager. All logic runs in the single `clk_60MHz` domain. SCK/WS/SD are treated as asynchronous inputs and are oversampled. Completed stereo frames are presented on a valid/ready port to the beamforming/FIFO stage.

---
 rtl/i2s_mic_rx.sv | 226 ++++++++++++++++++++++
 tb/tb_i2s_mic_rx.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_mic_rx.sv
// i2s_mic_rx: oversampled I2S microphone capture, LINES stereo lines to a one-entry valid/ready frame port.
// Optional build macro I2S_MIC_RX_FRAME_ERR_EN adds slot-length checking and the frame_err pulse.
`default_nettype none

module i2s_mic_rx #(
  parameter int LINES  = 4,
  parameter int DATA_W = 24,
  parameter int SLOT_W = 32
) (
  input  logic                    clk_in,
  input  logic                    rst,
  input  logic                    sck_in,
  input  logic                    ws_in,
  input  logic [LINES-1:0]        sd_in,
  output logic [LINES*DATA_W-1:0] out_data_l,
  output logic [LINES*DATA_W-1:0] out_data_r,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    ovf,
  output logic                    frame_err
);

  localparam int BUS_W = LINES * DATA_W;
  // Counter covers one whole frame so a stuck WS saturates instead of wrapping.
  localparam int CNT_W = $clog2(2 * SLOT_W);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(2 * SLOT_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_ALIGN = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } state_e;

  logic [2:0]       sck_sync_q;
  logic [1:0]       ws_sync_q;
  logic [LINES-1:0] sd_meta_q;
  logic [LINES-1:0] sd_sync_q;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             ws_prev_q, ws_prev_d;
  logic [BUS_W-1:0] shl_q, shl_d;
  logic [BUS_W-1:0] shr_q, shr_d;
  logic [BUS_W-1:0] out_l_q, out_l_d;
  logic [BUS_W-1:0] out_r_q, out_r_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;

  logic             sck_rise;
  logic             ws_s;
  logic             ws_chg;
  logic             ws_fall;
  logic             ws_rise;
  logic [CNT_W-1:0] bit_idx;
  logic             shift_en;
  logic             viol;
  logic             frame_done;
  logic             load;
  logic             drop;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      sck_sync_q <= 3'b000;
      ws_sync_q  <= 2'b00;
      sd_meta_q  <= '0;
      sd_sync_q  <= '0;
    end else begin
      sck_sync_q <= {sck_sync_q[1:0], sck_in};
      ws_sync_q  <= {ws_sync_q[0], ws_in};
      sd_meta_q  <= sd_in;
      sd_sync_q  <= sd_meta_q;
    end
  end

  assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
  assign ws_s     = ws_sync_q[1];
  assign ws_chg   = sck_rise & (ws_s != ws_prev_q);
  assign ws_fall  = ws_chg & ~ws_s;
  assign ws_rise  = ws_chg & ws_s;

  // bit_idx is the slot position of the bit sampled at this edge; index 0 is the one-bit WS delay.
  always_comb begin
    bit_idx = bit_cnt_q;
    if (ws_chg) begin
      bit_idx = '0;
    end else if (bit_cnt_q != CNT_MAX) begin
      bit_idx = bit_cnt_q + CNT_ONE;
    end else begin
      bit_idx = CNT_MAX;
    end
  end

  assign shift_en  = sck_rise && (bit_idx >= CNT_ONE) && (bit_idx <= DATA_LAST);
  assign bit_cnt_d = sck_rise ? bit_idx : bit_cnt_q;
  assign ws_prev_d = sck_rise ? ws_s : ws_prev_q;

`ifdef I2S_MIC_RX_FRAME_ERR_EN
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_W - 1);

  logic ferr_q;

  assign viol = (state_q != ST_ALIGN) &&
                ((ws_chg && (bit_cnt_q != SLOT_LAST)) ||
                 (sck_rise && !ws_chg && (bit_cnt_q == CNT_MAX - CNT_ONE)));

  always_ff @(posedge clk_in) begin
    if (rst) begin
      ferr_q <= 1'b0;
    end else begin
      ferr_q <= viol;
    end
  end

  assign frame_err = ferr_q;
`else
  assign viol      = 1'b0;
  assign frame_err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    frame_done = 1'b0;
    case (state_q)
      ST_ALIGN: begin
        if (ws_fall) begin
          state_d = ST_LEFT;
        end else begin
          state_d = ST_ALIGN;
        end
      end
      ST_LEFT: begin
        if (viol) begin
          state_d = ST_ALIGN;
        end else if (ws_rise) begin
          state_d = ST_RIGHT;
        end else begin
          state_d = ST_LEFT;
        end
      end
      ST_RIGHT: begin
        if (viol) begin
          state_d = ST_ALIGN;
        end else if (ws_fall) begin
          state_d    = ST_LEFT;
          frame_done = 1'b1;
        end else begin
          state_d = ST_RIGHT;
        end
      end
      default: begin
        state_d = ST_ALIGN;
      end
    endcase
  end

  // Each line's slot register shifts MSB first; exactly DATA_W shifts per slot replace all old bits.
  always_comb begin
    shl_d = shl_q;
    shr_d = shr_q;
    for (int k = 0; k < LINES; k++) begin
      if (shift_en && (state_q == ST_LEFT)) begin
        shl_d[k*DATA_W +: DATA_W] = {shl_q[k*DATA_W +: DATA_W-1], sd_sync_q[k]};
      end else begin
        shl_d[k*DATA_W +: DATA_W] = shl_q[k*DATA_W +: DATA_W];
      end
      if (shift_en && (state_q == ST_RIGHT)) begin
        shr_d[k*DATA_W +: DATA_W] = {shr_q[k*DATA_W +: DATA_W-1], sd_sync_q[k]};
      end else begin
        shr_d[k*DATA_W +: DATA_W] = shr_q[k*DATA_W +: DATA_W];
      end
    end
  end

  assign load = frame_done && (!valid_q || out_ready);
  assign drop = frame_done && valid_q && !out_ready;

  always_comb begin
    out_l_d = out_l_q;
    out_r_d = out_r_q;
    valid_d = valid_q;
    if (load) begin
      out_l_d = shl_q;
      out_r_d = shr_q;
      valid_d = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    ovf_d = ovf_q | drop;
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q   <= ST_ALIGN;
      bit_cnt_q <= '0;
      ws_prev_q <= 1'b0;
      shl_q     <= '0;
      shr_q     <= '0;
      out_l_q   <= '0;
      out_r_q   <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      ws_prev_q <= ws_prev_d;
      shl_q     <= shl_d;
      shr_q     <= shr_d;
      out_l_q   <= out_l_d;
      out_r_q   <= out_r_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
    end
  end

  assign out_data_l = out_l_q;
  assign out_data_r = out_r_q;
  assign out_valid  = valid_q;
  assign ovf        = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_i2s_mic_rx.sv
// tb_i2s_mic_rx: directed table-driven bench for i2s_mic_rx; frame_err expectations follow I2S_MIC_RX_FRAME_ERR_EN.
`timescale 1ns/1ps

module tb_i2s_mic_rx;

  typedef struct packed {
    logic [3:0][23:0] l;
    logic [3:0][23:0] r;
    logic [95:0]      exp_l;
    logic [95:0]      exp_r;
  } vec_t;

  logic        clk_in = 1'b0;
  logic        rst;
  logic        sck_in;
  logic        ws_in;
  logic [3:0]  sd_in;
  logic [95:0] out_data_l;
  logic [95:0] out_data_r;
  logic        out_valid;
  logic        out_ready;
  logic        ovf;
  logic        frame_err;

  int           total = 0;
  int           bad = 0;
  int           ferr_cnt = 0;
  logic [191:0] acc_q[$];
  vec_t         tbl[4];

  always #8 clk_in = ~clk_in;

  i2s_mic_rx #(.LINES(4), .DATA_W(24), .SLOT_W(32)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .sck_in    (sck_in),
    .ws_in     (ws_in),
    .sd_in     (sd_in),
    .out_data_l(out_data_l),
    .out_data_r(out_data_r),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ovf       (ovf),
    .frame_err (frame_err)
  );

  // Record every accepted frame and every frame_err cycle.
  always @(negedge clk_in) begin
    if (out_valid && out_ready) acc_q.push_back({out_data_l, out_data_r});
    if (frame_err) ferr_cnt++;
  end

  function automatic logic [191:0] acc_at(input int i);
    if (i < acc_q.size()) return acc_q[i];
    return '0;
  endfunction

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i,
                         input logic [23:0] l0, input logic [23:0] l1,
                         input logic [23:0] l2, input logic [23:0] l3,
                         input logic [23:0] r0, input logic [23:0] r1,
                         input logic [23:0] r2, input logic [23:0] r3,
                         input logic [95:0] el, input logic [95:0] er);
    tbl[i].l[0] = l0; tbl[i].l[1] = l1; tbl[i].l[2] = l2; tbl[i].l[3] = l3;
    tbl[i].r[0] = r0; tbl[i].r[1] = r1; tbl[i].r[2] = r2; tbl[i].r[3] = r3;
    tbl[i].exp_l = el;
    tbl[i].exp_r = er;
  endtask

  task automatic step(input bit jit);
    int d;
    @(posedge clk_in);
    d = jit ? int'($urandom_range(15, 1)) : 1;
    #(d);
  endtask

  // One slot: WS/SD change with SCK falling; slot position j (1..24) carries word bit 24-j.
  task automatic send_slot(input logic ws, input logic [3:0][23:0] w, input int nsck,
                           input bit jit, input bit pulse);
    for (int j = 0; j < nsck; j++) begin
      int per;
      int lo;
      per = jit ? int'($urandom_range(32, 28)) : 30;
      lo = per / 2;
      sck_in = 1'b0;
      ws_in  = ws;
      for (int k = 0; k < 4; k++) sd_in[k] = (j >= 1 && j <= 24) ? w[k][24-j] : 1'b0;
      repeat (lo) step(jit);
      sck_in = 1'b1;
      for (int c = 0; c < per - lo; c++) begin
        step(jit);
        if (pulse && j == 0 && c == 1) out_ready = 1'b1;
        if (pulse && j == 0 && c == 2) out_ready = 1'b0;
      end
    end
  endtask

  task automatic send_l(input int i, input int nsck, input bit jit, input bit pulse);
    send_slot(1'b0, tbl[i].l, nsck, jit, pulse);
  endtask

  task automatic send_r(input int i, input bit jit);
    send_slot(1'b1, tbl[i].r, 32, jit, 1'b0);
  endtask

  initial begin
    int base;
    int fbase;
    logic [3:0][23:0] junk;

    set_vec(0, 24'h800001, 24'h000000, 24'hFFFFFF, 24'h123456,
               24'h7FFFFE, 24'h000001, 24'h800000, 24'hABCDEF,
               96'h123456_FFFFFF_000000_800001, 96'hABCDEF_800000_000001_7FFFFE);
    set_vec(1, 24'h800001, 24'h5A5A5A, 24'h0F0F0F, 24'h123456,
               24'h7FFFFE, 24'hA5A5A5, 24'hF0F0F0, 24'hABCDEF,
               96'h123456_0F0F0F_5A5A5A_800001, 96'hABCDEF_F0F0F0_A5A5A5_7FFFFE);
    set_vec(2, 24'h000000, 24'h111111, 24'h222222, 24'h333333,
               24'h444444, 24'h555555, 24'h666666, 24'h777777,
               96'h333333_222222_111111_000000, 96'h777777_666666_555555_444444);
    set_vec(3, 24'h800001, 24'hC00003, 24'h3FFFFC, 24'h123456,
               24'h7FFFFE, 24'h000100, 24'h010000, 24'hABCDEF,
               96'h123456_3FFFFC_C00003_800001, 96'hABCDEF_010000_000100_7FFFFE);
    junk = {24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF};

    rst = 1'b1; sck_in = 1'b0; ws_in = 1'b0; sd_in = 4'h0; out_ready = 1'b1;
    repeat (4) @(posedge clk_in);
    @(negedge clk_in);
    chk("reset_valid", 192'(out_valid), 192'd0);
    chk("reset_ovf", 192'(ovf), 192'd0);
    chk("reset_ferr", 192'(frame_err), 192'd0);
    chk("reset_data", {out_data_l, out_data_r}, 192'd0);
    rst = 1'b0;

    // Basic capture: partial left and a full right before alignment must be discarded.
    base = acc_q.size();
    send_slot(1'b0, junk, 10, 1'b0, 1'b0);
    send_slot(1'b1, junk, 32, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send_l(i, 32, 1'b0, 1'b0);
      send_r(i, 1'b0);
    end
    send_l(1, 32, 1'b0, 1'b0);
    chk("basic_count", 192'(acc_q.size() - base), 192'd4);
    for (int i = 0; i < 4; i++) chk("basic_frame", acc_at(base + i), {tbl[i].exp_l, tbl[i].exp_r});

    // Backpressure: frame A held, frame B dropped.
    out_ready = 1'b0;
    base = acc_q.size();
    send_r(1, 1'b0);
    send_l(2, 32, 1'b0, 1'b0);
    chk("bp_valid_a", 192'(out_valid), 192'd1);
    chk("bp_data_a", {out_data_l, out_data_r}, {tbl[1].exp_l, tbl[1].exp_r});
    chk("bp_ovf_a", 192'(ovf), 192'd0);
    send_r(2, 1'b0);
    send_l(3, 32, 1'b0, 1'b0);
    chk("bp_valid_b", 192'(out_valid), 192'd1);
    chk("bp_data_held", {out_data_l, out_data_r}, {tbl[1].exp_l, tbl[1].exp_r});
    chk("bp_ovf_b", 192'(ovf), 192'd1);
    out_ready = 1'b1;
    repeat (3) @(negedge clk_in);
    chk("bp_valid_drop", 192'(out_valid), 192'd0);
    chk("bp_accepts", 192'(acc_q.size() - base), 192'd1);
    chk("bp_accept_data", acc_at(base), {tbl[1].exp_l, tbl[1].exp_r});

    // Reset at bit 10 of a right slot.
    send_slot(1'b1, tbl[3].r, 11, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    chk("rst_valid", 192'(out_valid), 192'd0);
    chk("rst_ovf", 192'(ovf), 192'd0);
    chk("rst_ferr", 192'(frame_err), 192'd0);
    chk("rst_data_l", 192'(out_data_l), 192'd0);
    chk("rst_data_r", 192'(out_data_r), 192'd0);
    rst = 1'b0;
    base = acc_q.size();
    send_slot(1'b1, tbl[3].r, 21, 1'b0, 1'b0);
    send_l(0, 32, 1'b0, 1'b0);
    send_r(0, 1'b0);
    send_l(2, 32, 1'b0, 1'b0);
    chk("rst_count", 192'(acc_q.size() - base), 192'd1);
    chk("rst_frame", acc_at(base), {tbl[0].exp_l, tbl[0].exp_r});

    // Accept of held frame E in the same cycle that frame F completes.
    out_ready = 1'b0;
    base = acc_q.size();
    send_r(2, 1'b0);
    send_l(3, 32, 1'b0, 1'b0);
    chk("sc_held", {out_data_l, out_data_r}, {tbl[2].exp_l, tbl[2].exp_r});
    send_r(3, 1'b0);
    send_l(0, 32, 1'b0, 1'b1);
    chk("sc_accepts", 192'(acc_q.size() - base), 192'd1);
    chk("sc_accept_data", acc_at(base), {tbl[2].exp_l, tbl[2].exp_r});
    chk("sc_valid", 192'(out_valid), 192'd1);
    chk("sc_new_data", {out_data_l, out_data_r}, {tbl[3].exp_l, tbl[3].exp_r});
    chk("sc_ovf", 192'(ovf), 192'd0);
    out_ready = 1'b1;
    repeat (3) @(negedge clk_in);
    chk("sc_drain", acc_at(base + 1), {tbl[3].exp_l, tbl[3].exp_r});

    // Shortened (30 SCK) left slot in frame H.
    base = acc_q.size();
    fbase = ferr_cnt;
    send_r(0, 1'b0);
    send_l(1, 30, 1'b0, 1'b0);
    send_r(1, 1'b0);
    send_l(2, 32, 1'b0, 1'b0);
    send_r(2, 1'b0);
    send_l(3, 32, 1'b0, 1'b0);
`ifdef I2S_MIC_RX_FRAME_ERR_EN
    chk("fe_pulses", 192'(ferr_cnt - fbase), 192'd1);
    chk("fe_count", 192'(acc_q.size() - base), 192'd2);
    chk("fe_before", acc_at(base), {tbl[0].exp_l, tbl[0].exp_r});
    chk("fe_resume", acc_at(base + 1), {tbl[2].exp_l, tbl[2].exp_r});
`else
    chk("fe_pulses", 192'(ferr_cnt - fbase), 192'd0);
    chk("fe_count", 192'(acc_q.size() - base), 192'd3);
    chk("fe_before", acc_at(base), {tbl[0].exp_l, tbl[0].exp_r});
    chk("fe_short", acc_at(base + 1), {tbl[1].exp_l, tbl[1].exp_r});
    chk("fe_resume", acc_at(base + 2), {tbl[2].exp_l, tbl[2].exp_r});
`endif

    // Jittered SCK period with asynchronous phase.
    base = acc_q.size();
    fbase = ferr_cnt;
    send_r(3, 1'b1);
    for (int i = 0; i < 4; i++) begin
      send_l(i, 32, 1'b1, 1'b0);
      send_r(i, 1'b1);
    end
    send_l(0, 32, 1'b1, 1'b0);
    chk("jit_count", 192'(acc_q.size() - base), 192'd5);
    chk("jit_first", acc_at(base), {tbl[3].exp_l, tbl[3].exp_r});
    for (int i = 0; i < 4; i++) chk("jit_frame", acc_at(base + 1 + i), {tbl[i].exp_l, tbl[i].exp_r});
    chk("jit_ferr", 192'(ferr_cnt - fbase), 192'd0);
    chk("jit_ovf", 192'(ovf), 192'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
